// File: rtl/stream_pkg.sv
// stream_pkg: shared state encoding and source-tag constants for the stream stages
package stream_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_G0 = 2'd1, ST_G1 = 2'd2} state_t;
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;
endpackage

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of two FWFT input FIFOs into one output FIFO with a source tag
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   fifo_in{0,1}_*        : FWFT input FIFOs (rd_en combinational, dout, empty)
//   fifo_out_*            : registered write strobe, data and source tag; full must be prog-full
//   grant                 : registered one-hot grant (01=in0, 10=in1, 00=idle)
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic              clock,
  input  logic              reset,
  output logic              fifo_in0_rd_en,
  input  logic [DWIDTH-1:0] fifo_in0_dout,
  input  logic              fifo_in0_empty,
  output logic              fifo_in1_rd_en,
  input  logic [DWIDTH-1:0] fifo_in1_dout,
  input  logic              fifo_in1_empty,
  output logic              fifo_out_wr_en,
  output logic [DWIDTH-1:0] fifo_out_din,
  output logic              fifo_out_src,
  input  logic              fifo_out_full,
  output logic [1:0]        grant
);
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic last;
  logic g0, g1, xfer, cur_empty, oth_empty, rel;
  assign g0 = state == ST_G0;
  assign g1 = state == ST_G1;
  assign cur_empty = g0 ? fifo_in0_empty : fifo_in1_empty;
  assign oth_empty = g0 ? fifo_in1_empty : fifo_in0_empty;
  assign fifo_in0_rd_en = g0 && !fifo_in0_empty && !fifo_out_full;
  assign fifo_in1_rd_en = g1 && !fifo_in1_empty && !fifo_out_full;
  assign xfer = fifo_in0_rd_en || fifo_in1_rd_en;
  // An empty granted input releases at once; a full stall never releases.
  assign rel = (g0 || g1) && (cur_empty || (xfer && burst_cnt == CNT_WIDTH'(BURST_LEN - 1)));
  // The state encoding doubles as the one-hot grant.
  assign grant = state;
  always_comb begin
    state_nx = state;
    if (state == ST_IDLE)
      state_nx = (!fifo_in0_empty && !fifo_in1_empty) ? (last ? ST_G0 : ST_G1) :
                 !fifo_in0_empty ? ST_G0 : !fifo_in1_empty ? ST_G1 : ST_IDLE;
    else if (rel)
      state_nx = !oth_empty ? (g0 ? ST_G1 : ST_G0) : !cur_empty ? state : ST_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      burst_cnt      <= '0;
      last           <= 1'b1;
      fifo_out_wr_en <= 1'b0;
      fifo_out_din   <= '0;
      fifo_out_src   <= SRC0;
    end else begin
      state          <= state_nx;
      burst_cnt      <= (rel || state == ST_IDLE) ? '0 : burst_cnt + CNT_WIDTH'(xfer);
      fifo_out_wr_en <= xfer;
      if (rel) last <= g1;
      if (xfer) begin
        fifo_out_din <= g0 ? fifo_in0_dout : fifo_in1_dout;
        fifo_out_src <= g0 ? SRC0 : SRC1;
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scenario and randomized checks of stream_rr_arbiter against a rule-level model
module tb_stream_rr_arbiter;
  localparam int DW = 32;
  localparam int BL = 16;
  logic clock = 0;
  logic reset = 1;
  logic rd0, rd1, e0, e1, wr, src, full;
  logic [DW-1:0] d0, d1, din;
  logic [1:0] grant;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] log_d[$];
  logic log_s[$];
  int log_c[$];
  int m_owner = -1;
  int m_cnt = 0;
  int m_last = 1;
  logic m_wr = 0;
  logic m_src = 0;
  logic [DW-1:0] m_din = '0;

  always #5 clock = ~clock;

  stream_rr_arbiter #(.DWIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .fifo_in0_rd_en(rd0), .fifo_in0_dout(d0), .fifo_in0_empty(e0),
    .fifo_in1_rd_en(rd1), .fifo_in1_dout(d1), .fifo_in1_empty(e1),
    .fifo_out_wr_en(wr), .fifo_out_din(din), .fifo_out_src(src),
    .fifo_out_full(full), .grant(grant)
  );

  function automatic logic [1:0] exp_grant(input int owner);
    return owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00;
  endfunction

  // One clock: present FIFO state, predict reads/owner from the arbitration rules, check outputs.
  task automatic cycle(input logic f, input logic rst);
    int take, n_owner;
    logic me, oe, rel;
    reset = rst;
    full = f;
    e0 = q0.size() == 0;
    e1 = q1.size() == 0;
    d0 = e0 ? '0 : q0[0];
    d1 = e1 ? '0 : q1[0];
    #1;
    take = -1;
    n_owner = m_owner;
    if (m_owner >= 0) begin
      me = m_owner == 0 ? e0 : e1;
      oe = m_owner == 0 ? e1 : e0;
      if (!me && !f) take = m_owner;
      rel = me || (take >= 0 && m_cnt == BL - 1);
      if (take >= 0) m_cnt++;
      if (rel) begin
        m_last = m_owner;
        m_cnt = 0;
        n_owner = !oe ? 1 - m_owner : (!me ? m_owner : -1);
      end
    end else
      n_owner = (!e0 && !e1) ? (m_last == 1 ? 0 : 1) : (!e0 ? 0 : (!e1 ? 1 : -1));
    compared++;
    if (rd0 !== (take == 0)) begin
      mismatched++;
      $display("FAIL rd_en0 cyc=%0d got=%b exp=%b", cyc, rd0, take == 0);
    end
    compared++;
    if (rd1 !== (take == 1)) begin
      mismatched++;
      $display("FAIL rd_en1 cyc=%0d got=%b exp=%b", cyc, rd1, take == 1);
    end
    if (take == 0) begin
      m_din = q0.pop_front();
      m_src = 0;
    end else if (take == 1) begin
      m_din = q1.pop_front();
      m_src = 1;
    end
    m_wr = take >= 0;
    m_owner = n_owner;
    if (rst) begin
      m_owner = -1; m_last = 1; m_cnt = 0; m_wr = 0; m_din = '0; m_src = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    compared++;
    if (wr !== m_wr) begin
      mismatched++;
      $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr, m_wr);
    end
    compared++;
    if (grant !== exp_grant(m_owner)) begin
      mismatched++;
      $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant(m_owner));
    end
    if (m_wr || rst) begin
      compared++;
      if (din !== m_din || src !== m_src) begin
        mismatched++;
        $display("FAIL data cyc=%0d got=%h/%b exp=%h/%b", cyc, din, src, m_din, m_src);
      end
    end
    if (wr === 1'b1) begin
      log_d.push_back(din);
      log_s.push_back(src);
      log_c.push_back(cyc);
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_owner >= 0 || m_wr) && n < 500) begin
      cycle(0, 0);
      n++;
    end
    compared++;
    if (n >= 500) begin
      mismatched++;
      $display("FAIL drain_timeout got=%0d cycles exp<500", n);
    end
  endtask

  task automatic clear_log();
    log_d.delete(); log_s.delete(); log_c.delete();
  endtask

  task automatic test_reset();
    cycle(0, 1);
    cycle(0, 1);
    compared++;
    if (wr !== 1'b0 || din !== '0 || src !== 1'b0 || grant !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_state got=%b/%h/%b/%b exp=0/0/0/00", wr, din, src, grant);
    end
  endtask

  task automatic test_single();
    int c0;
    clear_log();
    for (int i = 1; i <= 5; i++) q0.push_back(DW'(i));
    c0 = cyc;
    drain();
    compared++;
    if (log_d.size() != 5) begin
      mismatched++;
      $display("FAIL single_count got=%0d exp=5", log_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (log_d[i] !== DW'(i + 1) || log_s[i] !== 1'b0 || log_c[i] != c0 + 2 + i) begin
          mismatched++;
          $display("FAIL single_word%0d got=%0d/%b@%0d exp=%0d/0@%0d", i, log_d[i], log_s[i], log_c[i], i + 1, c0 + 2 + i);
        end
      end
    end
    compared++;
    if (grant !== 2'b00) begin
      mismatched++;
      $display("FAIL single_idle got=%b exp=00", grant);
    end
  endtask

  task automatic test_burst();
    logic es;
    cycle(0, 1);
    clear_log();
    for (int i = 0; i < 40; i++) begin
      q0.push_back(DW'(1000 + i));
      q1.push_back(DW'(2000 + i));
    end
    drain();
    compared++;
    if (log_d.size() != 80) begin
      mismatched++;
      $display("FAIL burst_count got=%0d exp=80", log_d.size());
    end else begin
      for (int k = 0; k < 80; k++) begin
        es = k < 64 ? 1'((k / 16) % 2) : (k < 72 ? 1'b0 : 1'b1);
        compared++;
        if (log_s[k] !== es) begin
          mismatched++;
          $display("FAIL burst_order k=%0d got=%b exp=%b", k, log_s[k], es);
        end
      end
      compared++;
      if (log_c[63] - log_c[0] != 63) begin
        mismatched++;
        $display("FAIL burst_bubble got=%0d exp=63", log_c[63] - log_c[0]);
      end
    end
  endtask

  task automatic test_empty_switch();
    cycle(0, 1);
    clear_log();
    for (int i = 0; i < 3; i++) q0.push_back(DW'(300 + i));
    for (int i = 0; i < 20; i++) q1.push_back(DW'(400 + i));
    drain();
    compared++;
    if (log_d.size() != 23) begin
      mismatched++;
      $display("FAIL switch_count got=%0d exp=23", log_d.size());
    end else begin
      compared++;
      if (log_s[2] !== 1'b0 || log_s[3] !== 1'b1 || log_c[3] - log_c[2] != 2 || log_c[19] - log_c[18] != 1) begin
        mismatched++;
        $display("FAIL switch_timing got=%b%b gaps %0d,%0d exp=01 gaps 2,1", log_s[2], log_s[3], log_c[3] - log_c[2], log_c[19] - log_c[18]);
      end
    end
  endtask

  task automatic test_backpressure();
    cycle(0, 1);
    clear_log();
    for (int i = 0; i < 20; i++) begin
      q0.push_back(DW'(500 + i));
      q1.push_back(DW'(600 + i));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0);
      compared++;
      if (grant !== 2'b01) begin
        mismatched++;
        $display("FAIL stall_grant i=%0d got=%b exp=01", i, grant);
      end
    end
    drain();
    compared++;
    if (log_s.size() != 40 || log_s[15] !== 1'b0 || log_s[16] !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_burst got=%0d words exp=40 with switch after 16", log_s.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'(700 + i));
      q1.push_back(DW'(800 + i));
    end
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 1);
    compared++;
    if (wr !== 1'b0 || grant !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_mid got=%b/%b exp=0/00", wr, grant);
    end
    cycle(0, 0);
    compared++;
    if (grant !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_first_grant got=%b exp=01", grant);
    end
    drain();
  endtask

  task automatic test_negative();
    cycle(0, 1);
    clear_log();
    q1.push_back(32'h8000_0001);
    drain();
    compared++;
    if (log_d.size() != 1 || log_d[0] !== 32'h8000_0001 || log_s[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL negative got=%0d words first=%h exp=1 word 80000001 src 1", log_d.size(), log_d.size() ? log_d[0] : '0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) q0.push_back($urandom);
      if ($urandom_range(0, 2) == 0) q1.push_back($urandom);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
    end
    drain();
  endtask

  initial begin
    full = 0; e0 = 1; e1 = 1; d0 = '0; d1 = '0;
    @(negedge clock);
    test_reset();
    test_single();
    test_burst();
    test_empty_switch();
    test_backpressure();
    test_reset_mid();
    test_negative();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
